// File: rtl/inst_fetch_queue_pkg.sv
// Shared constants and types for the instruction fetch queue.
// Widths match the core-wide PC and instruction buses.
package inst_fetch_queue_pkg;

    localparam int PC_W       = 64;
    localparam int INST_W     = 32;
    localparam int LINE_SLOTS = 4;
    localparam int LINE_W     = LINE_SLOTS * INST_W;
    localparam int IQ_DEPTH   = 16;

    localparam logic [PC_W-1:0]   ZERO_PC   = '0;
    localparam logic [INST_W-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/inst_fetch_queue_line_unpack.sv
// Splits a fetched cache line into up to four instruction/PC pairs
// starting at the slot addressed by the fetch PC.
module iq_line_unpack
    import inst_fetch_queue_pkg::*;
(
    input  logic [LINE_W-1:0]            in_line,
    input  logic [PC_W-1:0]              in_pc,
    input  logic [2:0]                   in_count,
    output logic [2:0]                   n,
    output logic [LINE_SLOTS*INST_W-1:0] slot_inst,
    output logic [LINE_SLOTS*PC_W-1:0]   slot_pc,
    output logic [LINE_SLOTS-1:0]        slot_we
);

    logic [1:0] start;
    logic [2:0] avail;

    always_comb begin
        start     = in_pc[3:2];
        avail     = 3'd4 - {1'b0, start};
        n         = (in_count < avail) ? in_count : avail;
        slot_inst = '0;
        slot_pc   = '0;
        slot_we   = '0;
        for (int k = 0; k < LINE_SLOTS; k++) begin
            logic [1:0] idx;
            idx = start + 2'(k);
            slot_inst[k*INST_W +: INST_W] = in_line[{idx, 5'b0} +: INST_W];
            slot_pc[k*PC_W +: PC_W]       = in_pc + PC_W'(4 * k);
            slot_we[k]                    = 3'(k) < n;
        end
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// Circular instruction queue between fetch and the dual decoders.
// Accepts up to one line per cycle, presents the two oldest entries.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [127:0]       in_line,
    input  logic [63:0]        in_pc,
    input  logic [2:0]         in_count,
    output logic               out0_valid,
    output logic [31:0]        out0_inst,
    output logic [63:0]        out0_pc,
    output logic               out1_valid,
    output logic [31:0]        out1_inst,
    output logic [63:0]        out1_pc,
    input  logic [1:0]         out_accept,
    output logic [PTR_W:0]     occupancy
);

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [PTR_W:0]    occ_q, occ_d;
    logic [INST_W-1:0] inst_mem_q [DEPTH];
    logic [INST_W-1:0] inst_mem_d [DEPTH];
    logic [PC_W-1:0]   pc_mem_q [DEPTH];
    logic [PC_W-1:0]   pc_mem_d [DEPTH];

    logic [2:0]                   n;
    logic [LINE_SLOTS*INST_W-1:0] slot_inst;
    logic [LINE_SLOTS*PC_W-1:0]   slot_pc;
    logic [LINE_SLOTS-1:0]        slot_we;

    logic             push;
    logic [2:0]       push_n;
    logic [1:0]       acc;
    logic [1:0]       pop;
    logic [PTR_W-1:0] head1;

    iq_line_unpack u_unpack (
        .in_line   (in_line),
        .in_pc     (in_pc),
        .in_count  (in_count),
        .n         (n),
        .slot_inst (slot_inst),
        .slot_pc   (slot_pc),
        .slot_we   (slot_we)
    );

    // Ready looks only at the registered count so a same-cycle pop
    // never feeds back into the upstream handshake.
    assign in_ready = occ_q <= (PTR_W+1)'(DEPTH - LINE_SLOTS);
    assign push     = in_valid && in_ready && !flush;
    assign push_n   = push ? n : 3'd0;
    assign acc      = out_accept[1] ? 2'd2 : {1'b0, out_accept[0]};
    assign pop      = (occ_q < (PTR_W+1)'(acc)) ? occ_q[1:0] : acc;

    always_comb begin
        head_d   = head_q + PTR_W'(pop);
        tail_d   = tail_q + PTR_W'(push_n);
        occ_d    = occ_q + (PTR_W+1)'(push_n) - (PTR_W+1)'(pop);
        inst_mem_d = inst_mem_q;
        pc_mem_d   = pc_mem_q;
        if (push) begin
            for (int k = 0; k < LINE_SLOTS; k++) begin
                if (slot_we[k]) begin
                    inst_mem_d[tail_q + PTR_W'(k)] = slot_inst[k*INST_W +: INST_W];
                    pc_mem_d[tail_q + PTR_W'(k)]   = slot_pc[k*PC_W +: PC_W];
                end
            end
        end
        if (flush) begin
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        inst_mem_q <= inst_mem_d;
        pc_mem_q   <= pc_mem_d;
    end

    assign head1      = head_q + PTR_W'(1);
    assign occupancy  = occ_q;
    assign out0_valid = occ_q != '0;
    assign out1_valid = occ_q >= (PTR_W+1)'(2);
    assign out0_inst  = out0_valid ? inst_mem_q[head_q] : ZERO_WORD;
    assign out0_pc    = out0_valid ? pc_mem_q[head_q] : ZERO_PC;
    assign out1_inst  = out1_valid ? inst_mem_q[head1] : ZERO_WORD;
    assign out1_pc    = out1_valid ? pc_mem_q[head1] : ZERO_PC;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: reset, truncation, throttling,
// flush, and a long wrapping stream checked against a small model.
module tb_inst_fetch_queue;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_line;
    logic [63:0]  in_pc;
    logic [2:0]   in_count;
    logic         out0_valid;
    logic [31:0]  out0_inst;
    logic [63:0]  out0_pc;
    logic         out1_valid;
    logic [31:0]  out1_inst;
    logic [63:0]  out1_pc;
    logic [1:0]   out_accept;
    logic [4:0]   occupancy;

    int passes = 0;
    int total  = 0;

    inst_fetch_queue dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_line    (in_line),
        .in_pc      (in_pc),
        .in_count   (in_count),
        .out0_valid (out0_valid),
        .out0_inst  (out0_inst),
        .out0_pc    (out0_pc),
        .out1_valid (out1_valid),
        .out1_inst  (out1_inst),
        .out1_pc    (out1_pc),
        .out_accept (out_accept),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [63:0] pc);
        return pc[31:0] ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [127:0] mk_line(input logic [63:0] pc);
        logic [127:0] l;
        logic [63:0]  base;
        base = {pc[63:4], 4'b0};
        for (int k = 0; k < 4; k++)
            l[32*k +: 32] = inst_of(base + 64'(4 * k));
        return l;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic push_line(input logic [63:0] pc, input logic [2:0] cnt);
        in_valid = 1'b1;
        in_pc    = pc;
        in_count = cnt;
        in_line  = mk_line(pc);
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        int mocc;
        int lines;
        int win;
        int p;
        bit pushed;
        bit timed_out;
        logic [63:0] exp_pc;
        logic [63:0] base;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_line = '0; in_pc = '0; in_count = '0; out_accept = 2'd0;
        step();
        step();
        rst = 1'b0;
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_v0", 64'(out0_valid), 64'd0);
        chk("rst_v1", 64'(out1_valid), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);

        push_line(64'h8000_0000, 3'd4);
        chk("full_occ", 64'(occupancy), 64'd4);
        chk("full_i0", 64'(out0_inst), 64'(inst_of(64'h8000_0000)));
        chk("full_p0", out0_pc, 64'h8000_0000);
        chk("full_i1", 64'(out1_inst), 64'(inst_of(64'h8000_0004)));
        chk("full_p1", out1_pc, 64'h8000_0004);

        push_line(64'h8000_0008, 3'd4);
        chk("trunc_occ", 64'(occupancy), 64'd6);
        out_accept = 2'd2;
        step();
        step();
        out_accept = 2'd0;
        chk("trunc_after_pop_occ", 64'(occupancy), 64'd2);
        chk("trunc_i0", 64'(out0_inst), 64'(inst_of(64'h8000_0008)));
        chk("trunc_p0", out0_pc, 64'h8000_0008);
        chk("trunc_i1", 64'(out1_inst), 64'(inst_of(64'h8000_000C)));
        chk("trunc_p1", out1_pc, 64'h8000_000C);

        push_line(64'h9000_0000, 3'd4);
        push_line(64'h9000_0010, 3'd4);
        push_line(64'h9000_0020, 3'd3);
        chk("fill_occ13", 64'(occupancy), 64'd13);
        chk("fill_ready0", 64'(in_ready), 64'd0);
        out_accept = 2'd2;
        push_line(64'h9000_0030, 3'd4);
        chk("drop_occ", 64'(occupancy), 64'd11);
        chk("drop_ready", 64'(in_ready), 64'd1);
        chk("drop_p0", out0_pc, 64'h9000_0000);

        for (int i = 0; i < 5; i++) step();
        chk("occ1", 64'(occupancy), 64'd1);
        chk("occ1_p0", out0_pc, 64'h9000_0028);
        chk("occ1_v1", 64'(out1_valid), 64'd0);
        step();
        out_accept = 2'd0;
        chk("empty_occ", 64'(occupancy), 64'd0);
        chk("empty_v0", 64'(out0_valid), 64'd0);
        chk("empty_v1", 64'(out1_valid), 64'd0);
        chk("empty_i0", 64'(out0_inst), 64'd0);
        chk("empty_p0", out0_pc, 64'd0);
        out_accept = 2'd3;
        step();
        out_accept = 2'd0;
        chk("empty_accept_ignored", 64'(occupancy), 64'd0);

        push_line(64'hA000_0000, 3'd4);
        push_line(64'hA000_0010, 3'd2);
        chk("pre_flush_occ", 64'(occupancy), 64'd6);
        flush = 1'b1;
        out_accept = 2'd2;
        push_line(64'hA000_0020, 3'd4);
        flush = 1'b0;
        out_accept = 2'd0;
        chk("flush_occ", 64'(occupancy), 64'd0);
        chk("flush_ready", 64'(in_ready), 64'd1);
        chk("flush_v0", 64'(out0_valid), 64'd0);
        step();
        chk("flush_hold_occ", 64'(occupancy), 64'd0);

        base = 64'hC000_0000;
        exp_pc = base;
        mocc = 0;
        lines = 0;
        win = 0;
        timed_out = 1'b1;
        for (int c = 0; c < 300; c++) begin
            if (lines >= 40 && mocc == 0) begin
                timed_out = 1'b0;
                break;
            end
            chk("st_occ", 64'(occupancy), 64'(mocc));
            chk("st_ready", 64'(in_ready), 64'(mocc <= 12));
            chk("st_v0", 64'(out0_valid), 64'(mocc >= 1));
            chk("st_v1", 64'(out1_valid), 64'(mocc >= 2));
            if (mocc >= 1) begin
                chk("st_p0", out0_pc, exp_pc);
                chk("st_i0", 64'(out0_inst), 64'(inst_of(exp_pc)));
            end
            if (mocc >= 2) begin
                chk("st_p1", out1_pc, exp_pc + 64'd4);
                chk("st_i1", 64'(out1_inst), 64'(inst_of(exp_pc + 64'd4)));
            end
            in_valid   = lines < 40;
            in_pc      = base + 64'(16 * lines);
            in_count   = 3'd4;
            in_line    = mk_line(in_pc);
            out_accept = 2'd2;
            p = (mocc < 2) ? mocc : 2;
            pushed = in_valid && (mocc <= 12);
            if (pushed && c >= 20 && c < 40) win++;
            mocc = mocc + (pushed ? 4 : 0) - p;
            exp_pc = exp_pc + 64'(4 * p);
            if (pushed) lines++;
            step();
        end
        in_valid = 1'b0;
        out_accept = 2'd0;
        chk("st_timeout", 64'(timed_out), 64'd0);
        chk("st_final_pc", exp_pc, base + 64'd640);
        chk("st_final_occ", 64'(occupancy), 64'd0);
        chk("st_throttle", 64'(win), 64'd10);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
